// File: rtl/dc_token_ring_fifo_wr_arbiter.sv
// Round-robin write-port arbiter: one token holder at a time feeds a FIFO,
// with per-tenure burst limiting and a wrapping accepted-write counter.
module dc_token_ring_fifo_wr_arbiter #(
   parameter int N_REQ      = 4,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_BURST  = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [N_REQ-1:0]            req_valid_i,
   input  logic [N_REQ*DATA_WIDTH-1:0] req_data_i,
   output logic [N_REQ-1:0]            req_ready_o,
   input  logic                        fifo_ready_i,
   output logic                        fifo_wr_en_o,
   output logic [DATA_WIDTH-1:0]       fifo_data_o,
   output logic [N_REQ-1:0]            grant_o,
   output logic                        busy_o,
   output logic [CNT_WIDTH-1:0]        wr_count_o
);

   localparam int OW  = $clog2(N_REQ);
   localparam int OW1 = OW + 1;
   localparam logic [7:0]    LAST_BEAT = 8'(MAX_BURST - 1);
   localparam logic [OW-1:0] LAST_IDX  = OW'(N_REQ - 1);
   localparam logic [OW:0]   N_EXT     = OW1'(N_REQ);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t                state, state_nxt;
   logic [OW-1:0]         owner, owner_nxt;
   logic [OW-1:0]         ptr, ptr_nxt;
   logic [7:0]            burst_cnt, burst_cnt_nxt;
   logic [CNT_WIDTH-1:0]  wr_count, wr_count_nxt;
   logic [N_REQ-1:0]      grant, grant_nxt;

   logic [N_REQ-1:0]      rot;
   logic [OW-1:0]         off;
   logic [OW:0]           sum;
   logic [OW-1:0]         pick;
   logic                  pick_vld;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  owner_valid;
   logic                  wr_en;
   logic                  rel;

   // Rotate valids so the scan origin sits at bit 0, take the lowest set bit,
   // then map the offset back to an absolute index.
   always_comb begin
      rot      = N_REQ'({req_valid_i, req_valid_i} >> ptr);
      off      = '0;
      pick_vld = |req_valid_i;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (rot[i]) off = OW'(i);
      end
      sum = {1'b0, ptr} + {1'b0, off};
      if (sum >= N_EXT) sum = sum - N_EXT;
      pick = sum[OW-1:0];
   end

   always_comb begin
      sel_data = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (owner == OW'(k)) sel_data = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   assign owner_valid  = req_valid_i[owner];
   assign wr_en        = (state == BUSY) && owner_valid && fifo_ready_i;
   assign fifo_wr_en_o = wr_en;
   assign fifo_data_o  = (state == BUSY) ? sel_data : '0;
   assign grant_o      = grant;
   assign busy_o       = (state == BUSY);
   assign wr_count_o   = wr_count;

   always_comb begin
      req_ready_o = '0;
      if (state == BUSY) req_ready_o[owner] = fifo_ready_i;
   end

   always_comb begin
      state_nxt     = state;
      owner_nxt     = owner;
      ptr_nxt       = ptr;
      burst_cnt_nxt = burst_cnt;
      wr_count_nxt  = wr_count;
      grant_nxt     = grant;
      rel           = 1'b0;
      case (state)
         IDLE: begin
            if (pick_vld) begin
               owner_nxt     = pick;
               burst_cnt_nxt = '0;
               grant_nxt     = N_REQ'(1) << pick;
               state_nxt     = BUSY;
            end
         end
         BUSY: begin
            if (wr_en) begin
               wr_count_nxt  = wr_count + 1'b1;
               burst_cnt_nxt = burst_cnt + 8'd1;
               if (burst_cnt == LAST_BEAT) rel = 1'b1;
            end else if (!owner_valid) begin
               rel = 1'b1;
            end
            // A stalled FIFO with valid data keeps the token indefinitely.
            if (rel) begin
               ptr_nxt   = (owner == LAST_IDX) ? '0 : owner + 1'b1;
               grant_nxt = '0;
               state_nxt = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= IDLE;
         owner     <= '0;
         ptr       <= '0;
         burst_cnt <= '0;
         wr_count  <= '0;
         grant     <= '0;
      end else begin
         state     <= state_nxt;
         owner     <= owner_nxt;
         ptr       <= ptr_nxt;
         burst_cnt <= burst_cnt_nxt;
         wr_count  <= wr_count_nxt;
         grant     <= grant_nxt;
      end
   end

endmodule

// File: tb/tb_dc_token_ring_fifo_wr_arbiter.sv
// Scoreboard bench for dc_token_ring_fifo_wr_arbiter: directed stimulus queues
// expected FIFO writes; a negedge monitor pops and compares each strobe.
module tb_dc_token_ring_fifo_wr_arbiter;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   valid;
   logic [127:0] data;
   logic [3:0]   req_ready;
   logic         fifo_ready;
   logic         wr_en;
   logic [31:0]  fifo_data;
   logic [3:0]   grant;
   logic         busy;
   logic [15:0]  wr_count;

   logic [1:0]   w_valid;
   logic [15:0]  w_data;
   logic [1:0]   w_req_ready;
   logic         w_ready;
   logic         w_wr_en;
   logic [7:0]   w_fifo_data;
   logic [1:0]   w_grant;
   logic         w_busy;
   logic [3:0]   w_count;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  grant;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] data_base;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   dc_token_ring_fifo_wr_arbiter #(
      .N_REQ(4), .DATA_WIDTH(32), .MAX_BURST(4), .CNT_WIDTH(16)
   ) dut (
      .clk_i(clk), .rst_i(rst), .req_valid_i(valid), .req_data_i(data),
      .req_ready_o(req_ready), .fifo_ready_i(fifo_ready), .fifo_wr_en_o(wr_en),
      .fifo_data_o(fifo_data), .grant_o(grant), .busy_o(busy), .wr_count_o(wr_count)
   );

   dc_token_ring_fifo_wr_arbiter #(
      .N_REQ(2), .DATA_WIDTH(8), .MAX_BURST(1), .CNT_WIDTH(4)
   ) dut_wrap (
      .clk_i(clk), .rst_i(rst), .req_valid_i(w_valid), .req_data_i(w_data),
      .req_ready_o(w_req_ready), .fifo_ready_i(w_ready), .fifo_wr_en_o(w_wr_en),
      .fifo_data_o(w_fifo_data), .grant_o(w_grant), .busy_o(w_busy), .wr_count_o(w_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] dw(input int k);
      return data_base ^ (32'h1111_1111 * k);
   endfunction

   task automatic set_data(input logic [31:0] base);
      data_base = base;
      for (int k = 0; k < 4; k++) data[k*32 +: 32] = dw(k);
   endtask

   task automatic push_n(input int k, input int n);
      exp_t e;
      e.data  = dw(k);
      e.grant = 4'(1) << k;
      for (int i = 0; i < n; i++) exp_q.push_back(e);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Monitor: every strobe must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst) begin
         chk("no_write_in_reset", {31'd0, wr_en}, 32'd0);
      end else if (wr_en) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_write", {31'd0, wr_en}, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("write_data", fifo_data, e.data);
            chk("write_grant", {28'd0, grant}, {28'd0, e.grant});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; valid = '0; fifo_ready = 1'b0; data = '0;
      w_valid = '0; w_ready = 1'b0; w_data = {8'hB1, 8'hA0};
      set_data(32'h1000_0001);
      repeat (3) tick;
      chk("reset_grant", {28'd0, grant}, 32'd0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_count", {16'd0, wr_count}, 32'd0);
      chk("reset_wr_en", {31'd0, wr_en}, 32'd0);
      chk("reset_data", fifo_data, 32'd0);
      chk("reset_ready", {28'd0, req_ready}, 32'd0);

      // Single requester streaming: 4 writes per 5 cycles.
      rst = 1'b0; valid = 4'b0010; fifo_ready = 1'b1;
      push_n(1, 16);
      repeat (20) tick;
      chk("stream_count", {16'd0, wr_count}, 32'd16);
      chk("stream_idle", {31'd0, busy}, 32'd0);

      // Owner 2 gets two writes, then asynchronous reset mid-burst.
      valid = 4'b0100;
      push_n(2, 2);
      repeat (3) tick;
      chk("pre_reset_grant", {28'd0, grant}, 32'h4);
      chk("pre_reset_count", {16'd0, wr_count}, 32'd18);
      #2 rst = 1'b1;
      #1;
      chk("async_wr_en", {31'd0, wr_en}, 32'd0);
      chk("async_grant", {28'd0, grant}, 32'd0);
      chk("async_busy", {31'd0, busy}, 32'd0);
      chk("async_count", {16'd0, wr_count}, 32'd0);

      // Round-robin from ptr 0 after reset, wrapping 3 -> 0.
      tick;
      rst = 1'b0; valid = 4'b1111;
      set_data(32'h2000_00A5);
      push_n(0, 4); push_n(1, 4); push_n(2, 4); push_n(3, 4); push_n(0, 4);
      tick;
      chk("rr_first_grant", {28'd0, grant}, 32'h1);
      repeat (24) tick;
      chk("rr_count", {16'd0, wr_count}, 32'd20);
      chk("rr_idle", {31'd0, busy}, 32'd0);

      // Strict AND: owner 0 (scan from ptr 1 wraps to 0).
      valid = 4'b0001; fifo_ready = 1'b0;
      tick;
      chk("and_grant", {28'd0, grant}, 32'h1);
      chk("and_busy", {31'd0, busy}, 32'd1);
      chk("and_stall_wr_en", {31'd0, wr_en}, 32'd0);
      chk("and_stall_ready", {28'd0, req_ready}, 32'd0);
      tick;
      valid = 4'b0000; fifo_ready = 1'b1;
      #1;
      chk("and_novalid_wr_en", {31'd0, wr_en}, 32'd0);
      chk("and_novalid_ready", {28'd0, req_ready}, 32'h1);
      tick;
      chk("and_release", {31'd0, busy}, 32'd0);
      chk("and_count", {16'd0, wr_count}, 32'd20);

      // Stall holding: owner 3 writes once, stalls 10 cycles, finishes burst.
      valid = 4'b1001; fifo_ready = 1'b1;
      set_data(32'h3C00_0F0F);
      push_n(3, 4);
      tick;
      chk("stall_grant", {28'd0, grant}, 32'h8);
      tick;
      fifo_ready = 1'b0;
      chk("stall_first_count", {16'd0, wr_count}, 32'd21);
      for (int i = 0; i < 10; i++) begin
         tick;
         chk("stall_hold_grant", {28'd0, grant}, 32'h8);
         chk("stall_hold_wr_en", {31'd0, wr_en}, 32'd0);
      end
      fifo_ready = 1'b1;
      repeat (3) tick;
      chk("stall_release", {31'd0, busy}, 32'd0);
      chk("stall_count", {16'd0, wr_count}, 32'd24);
      tick;
      chk("stall_next_owner", {28'd0, grant}, 32'h1);
      valid = 4'b0000;
      tick;
      chk("final_idle", {31'd0, busy}, 32'd0);
      chk("final_count", {16'd0, wr_count}, 32'd24);

      // MAX_BURST=1, CNT_WIDTH=4: alternate owners, 17 writes wrap to 1.
      w_valid = 2'b11; w_ready = 1'b1;
      for (int i = 1; i <= 34; i++) begin
         tick;
         if (i % 2 == 1) begin
            if (((i - 1) / 2) % 2 == 0) begin
               chk("wrap_grant", {30'd0, w_grant}, 32'h1);
               chk("wrap_data", {24'd0, w_fifo_data}, 32'hA0);
            end else begin
               chk("wrap_grant", {30'd0, w_grant}, 32'h2);
               chk("wrap_data", {24'd0, w_fifo_data}, 32'hB1);
            end
            chk("wrap_wr_en", {31'd0, w_wr_en}, 32'd1);
         end else begin
            chk("wrap_gap_grant", {30'd0, w_grant}, 32'd0);
            chk("wrap_gap_wr_en", {31'd0, w_wr_en}, 32'd0);
         end
         if (i == 32) chk("wrap_count_16", {28'd0, w_count}, 32'd0);
      end
      w_valid = 2'b00;
      chk("wrap_count_17", {28'd0, w_count}, 32'd1);

      tick;
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dc_token_ring_fifo_wr_arbiter.md
# dc_token_ring_fifo_wr_arbiter

Round-robin controller sharing the write port of one token-ring FIFO between `N_REQ` requesters. Exactly one requester holds the write token at a time. The FIFO write strobe is asserted only when the token holder's valid and the FIFO's ready are both high. The block sits between the requester-side datapaths and the FIFO input (`din`) port. It owns grant sequencing, burst limiting and a write-count statistic.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..16)
- `DATA_WIDTH`, 32, FIFO word width
- `MAX_BURST`, 4, maximum writes per token tenure (1..255)
- `CNT_WIDTH`, 16, width of the write statistic counter

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge
- `rst_i`  in  1  asynchronous, active-high reset
- `req_valid_i`  in  N_REQ  per-requester data valid
- `req_data_i`  in  N_REQ*DATA_WIDTH  requester k data at bits [k*DATA_WIDTH +: DATA_WIDTH]
- `req_ready_o`  out  N_REQ  per-requester ready; only the owner's bit may be high
- `fifo_ready_i`  in  1  FIFO can accept a word (not full)
- `fifo_wr_en_o`  out  1  FIFO write strobe
- `fifo_data_o`  out  DATA_WIDTH  FIFO write data
- `grant_o`  out  N_REQ  one-hot token owner; all-zero when idle
- `busy_o`  out  1  a token is held
- `wr_count_o`  out  CNT_WIDTH  total accepted writes, wraps modulo 2^CNT_WIDTH

## Operation
- State machine with two states:
  - IDLE: no owner.
  - BUSY: `owner` register is valid.
- Registers: `state`, `owner` (clog2 N_REQ), `ptr` (round-robin start index), `burst_cnt` (8 bit), `wr_count`.
- IDLE:
  - If any `req_valid_i` is set, select the first set index scanning `ptr`, `ptr+1`, … modulo N_REQ.
  - Load it into `owner`, clear `burst_cnt`, go to BUSY.
  - Otherwise stay in IDLE.
- BUSY, combinational outputs:
  - `req_ready_o[owner] = fifo_ready_i`; all other bits 0.
  - `fifo_wr_en_o = req_valid_i[owner] & fifo_ready_i`. This must be a strict AND; a write with invalid data or into a full FIFO is forbidden.
  - `fifo_data_o` = slice `owner` of `req_data_i`.
- BUSY, transitions (evaluated at the clock edge):
  - If `fifo_wr_en_o` is high: `wr_count` +1 and `burst_cnt` +1. If `burst_cnt == MAX_BURST-1` before the increment, release the token.
  - Else if `req_valid_i[owner] == 0`, release the token.
  - Else (valid high, FIFO stalled): hold the token, with no limit.
  - Release: `ptr <= (owner+1) mod N_REQ`, go to IDLE.
- Outside BUSY: `fifo_wr_en_o = 0`, `fifo_data_o = 0`, `req_ready_o = 0`, `grant_o = 0`.
- Requesters other than the owner are ignored while BUSY; their valid may stay high.

## Timing
- Reset (asynchronous, any time, including mid-burst):
  - Registers: state IDLE, `owner` 0, `ptr` 0, `burst_cnt` 0, `wr_count` 0.
  - Outputs: `fifo_wr_en_o` 0, `fifo_data_o` 0, `req_ready_o` 0, `grant_o` 0, `busy_o` 0, `wr_count_o` 0.
  - No write strobe may appear while `rst_i` is high.
- Grant latency: a valid sampled at edge t in IDLE gives `grant_o` and `busy_o` high after edge t. The first write is possible in that same cycle.
- Token-release gap: every release costs exactly one IDLE cycle with no write. Sustained throughput with one requester and MAX_BURST=4 is therefore 4 writes per 5 cycles.
- `fifo_wr_en_o`, `req_ready_o` and `fifo_data_o` are combinational from registered `owner`/`state` and the live inputs. `grant_o`, `busy_o` and `wr_count_o` are purely registered.
- Edge cases:
  - `ptr` wrap-around: after owner N_REQ-1 releases, scanning starts at 0.
  - Simultaneous requests: the lowest index at or after `ptr` wins.
  - A valid drop at the same cycle as a final write: a single release, no double count.
  - `wr_count` overflow wraps to 0 with no flag.
  - `MAX_BURST=1`: release after every write.

## Test plan
- Reset mid-burst: owner 2, `burst_cnt` 2, assert `rst_i` asynchronously -> `fifo_wr_en_o`, `grant_o`, `busy_o` and `wr_count_o` all 0 immediately; after deassert, the next grant scans from 0.
- Strict-AND check: owner 0 with valid=0 and fifo_ready=1, then valid=1 and fifo_ready=0 -> `fifo_wr_en_o` stays 0 in both cycles; `wr_count_o` unchanged.
- Single requester streaming: valid[1] held high, FIFO always ready, 20 cycles from reset -> `wr_count_o` = 16 (groups of 4 writes separated by 1 idle cycle); `fifo_data_o` equals `req_data_i` slice 1 on each strobe.
- Round-robin fairness: all 4 valid high, FIFO ready -> grant order 0,1,2,3,0, each with exactly 4 writes; `ptr` wraps 3→0.
- Stall holding: owner 3 with valid high, `fifo_ready_i` low for 10 cycles -> `grant_o` stays 4'b1000 and no writes occur; after ready returns, the remaining burst completes and the token passes to index 0.
- Counter wrap: with CNT_WIDTH=4, perform 17 writes -> `wr_count_o` = 1.
